// File: rtl/id_cycle.sv
// Instruction-decode stage: IF/ID latch, field decode, 32-entry register file,
// ID/EX latch and load-use interlock. Pipeline latches move on the falling edge.
module id_cycle #(
  parameter int NUM_REGS = 32,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     if_ir,
  input  logic [XLEN-1:0] if_pc,
  input  logic            is_Branch_Taken,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            isDataInterLock,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_rs_val,
  output logic [XLEN-1:0] id_rt_val,
  output logic [XLEN-1:0] id_imm,
  output logic [4:0]      id_rd,
  output logic [5:0]      id_opcode,
  output logic [5:0]      id_funct,
  output logic            id_is_load,
  output logic            id_is_store,
  output logic            id_is_branch,
  output logic            id_reg_write
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  logic            ifid_valid_r;
  logic [31:0]     ifid_ir_r;
  logic [XLEN-1:0] ifid_pc_r;
  logic [XLEN-1:0] regs_r [NUM_REGS];

  logic [5:0]      opcode_s;
  logic [4:0]      rs_s;
  logic [4:0]      rt_s;
  logic [4:0]      dest_s;
  logic            reg_write_s;
  logic            is_load_s;
  logic            is_store_s;
  logic            is_branch_s;
  logic            uses_rt_s;
  logic [XLEN-1:0] rs_val_s;
  logic [XLEN-1:0] rt_val_s;
  logic            hz_s;
  logic            advance_s;

  assign opcode_s = ifid_ir_r[31:26];
  assign rs_s     = ifid_ir_r[25:21];
  assign rt_s     = ifid_ir_r[20:16];

  // Control decode of the instruction held in IF/ID.
  always_comb begin
    dest_s      = 5'd0;
    reg_write_s = 1'b0;
    is_load_s   = 1'b0;
    is_store_s  = 1'b0;
    is_branch_s = 1'b0;
    uses_rt_s   = 1'b0;
    case (opcode_s)
      OP_RTYPE: begin reg_write_s = 1'b1; dest_s = ifid_ir_r[15:11]; uses_rt_s = 1'b1; end
      OP_ADDI:  begin reg_write_s = 1'b1; dest_s = rt_s; end
      OP_LW:    begin reg_write_s = 1'b1; is_load_s = 1'b1; dest_s = rt_s; end
      OP_SW:    begin is_store_s = 1'b1; uses_rt_s = 1'b1; end
      OP_BEQ:   begin is_branch_s = 1'b1; uses_rt_s = 1'b1; end
      default:  begin dest_s = 5'd0; end
    endcase
  end

  // Combinational operand read; a rising-edge writeback lands before the falling-edge capture.
  always_comb begin
    if (rs_s == 5'd0) rs_val_s = '0;
    else              rs_val_s = regs_r[rs_s];
    if (rt_s == 5'd0) rt_val_s = '0;
    else              rt_val_s = regs_r[rt_s];
  end

  // Load-use hazard against the load currently in ID/EX.
  assign hz_s = ifid_valid_r && id_valid && id_is_load && (id_rd != 5'd0) &&
                ((id_rd == rs_s) || (uses_rt_s && (id_rd == rt_s)));
  assign isDataInterLock = hz_s && !is_Branch_Taken;
  assign advance_s = ifid_valid_r && !hz_s && !is_Branch_Taken;

  // Register file: rising-edge write, register 0 never written.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= '0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      regs_r[wb_rd] <= wb_data;
    end
  end

  // IF/ID latch: flush empties it, a stall holds it, otherwise it takes the fetched word.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid_r <= 1'b0;
      ifid_ir_r    <= '0;
      ifid_pc_r    <= '0;
    end else if (is_Branch_Taken) begin
      ifid_valid_r <= 1'b0;
      ifid_ir_r    <= '0;
      ifid_pc_r    <= '0;
    end else if (!hz_s) begin
      ifid_valid_r <= 1'b1;
      ifid_ir_r    <= if_ir;
      ifid_pc_r    <= if_pc;
    end
  end

  // ID/EX latch: flush, stall and IF/ID bubbles all produce an all-zero bubble.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      id_valid <= 1'b0; id_pc <= '0; id_rs_val <= '0; id_rt_val <= '0; id_imm <= '0;
      id_rd <= 5'd0; id_opcode <= 6'd0; id_funct <= 6'd0;
      id_is_load <= 1'b0; id_is_store <= 1'b0; id_is_branch <= 1'b0; id_reg_write <= 1'b0;
    end else if (advance_s) begin
      id_valid     <= 1'b1;
      id_pc        <= ifid_pc_r;
      id_rs_val    <= rs_val_s;
      id_rt_val    <= rt_val_s;
      id_imm       <= {{(XLEN-16){ifid_ir_r[15]}}, ifid_ir_r[15:0]};
      id_rd        <= reg_write_s ? dest_s : 5'd0;
      id_opcode    <= opcode_s;
      id_funct     <= ifid_ir_r[5:0];
      id_is_load   <= is_load_s;
      id_is_store  <= is_store_s;
      id_is_branch <= is_branch_s;
      id_reg_write <= reg_write_s;
    end else begin
      id_valid <= 1'b0; id_pc <= '0; id_rs_val <= '0; id_rt_val <= '0; id_imm <= '0;
      id_rd <= 5'd0; id_opcode <= 6'd0; id_funct <= 6'd0;
      id_is_load <= 1'b0; id_is_store <= 1'b0; id_is_branch <= 1'b0; id_reg_write <= 1'b0;
    end
  end

endmodule
